fractal_raster_scan: RTL and testbench

- Sequential driver and consumer for the combinational fractal iteration core.
- Scans the pixel raster and presents x/y coordinates to the core.
- Samples the core's per-iteration "still bounded" vector, decodes it into an escape count, and streams one pixel record per coordinate to the framebuffer writer over a valid/ready handshake.
- Sits between frame control (start/abort) and the framebuffer write port.

---
 rtl/fractal_raster_scan_if.sv | 28 ++
 rtl/fractal_raster_scan.sv | 176 +++++++++++++++++
 tb/tb_fractal_raster_scan.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fractal_raster_scan_if.sv
// Pixel record stream from the raster scanner to the framebuffer writer.
// Handshake: a record moves when pix_valid && pix_ready; while pix_valid is high and not accepted, the record holds.
interface fractal_raster_scan_if #(
    parameter int AW  = 20,
    parameter int ITW = 5
) ();
    logic           pix_valid;
    logic           pix_ready;
    logic [AW-1:0]  pix_addr;
    logic [ITW-1:0] pix_iter;
    logic           pix_inside;

    modport master (
        output pix_valid,
        output pix_addr,
        output pix_iter,
        output pix_inside,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_addr,
        input  pix_iter,
        input  pix_inside,
        output pix_ready
    );
endinterface

// File: rtl/fractal_raster_scan.sv
// Raster scanner for the combinational fractal core: walks x/y, decodes the
// core's bounded vector into an escape count and streams one record per pixel.
module fractal_raster_scan #(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int MAX_ITER = 20,
    parameter int ITW      = 5,
    parameter int AW       = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [11:0]         x_out,
    output logic [11:0]         y_out,
    input  logic [MAX_ITER:0]   iter_in,
    fractal_raster_scan_if.master pix,
    output logic [1:0]          dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [11:0] X_LAST = 12'(H_RES - 1);
    localparam logic [11:0] Y_LAST = 12'(V_RES - 1);

    logic [1:0]     state_q, state_d;
    logic [11:0]    x_q, x_d;
    logic [11:0]    y_q, y_d;
    logic [AW-1:0]  addr_cnt_q, addr_cnt_d;
    logic           busy_q, busy_d;
    logic           valid_q, valid_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [ITW-1:0] iter_q, iter_d;
    logic           inside_q, inside_d;
    logic           done_d;

    logic           capture;
    logic           accept;
    logic           last_pix;
    logic [ITW-1:0] dec_iter;
    logic           dec_inside;
    logic           unused_top_bit;

    // The core never drives the top compare bit.
    assign unused_top_bit = iter_in[MAX_ITER];

    always_comb begin
        dec_iter = ITW'(MAX_ITER);
        for (int i = MAX_ITER - 1; i >= 0; i--) begin
            if (!iter_in[i]) begin
                dec_iter = ITW'(i);
            end
        end
    end

    assign dec_inside = &iter_in[MAX_ITER-1:0];

    assign capture  = (state_q == ST_RUN) && (!valid_q || pix.pix_ready);
    assign accept   = valid_q && pix.pix_ready;
    assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        addr_cnt_d = addr_cnt_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        iter_d     = iter_q;
        inside_d   = inside_q;
        done_d     = 1'b0;

        if (abort) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            valid_d    = 1'b0;
            x_d        = '0;
            y_d        = '0;
            addr_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d    = ST_RUN;
                        busy_d     = 1'b1;
                        x_d        = '0;
                        y_d        = '0;
                        addr_cnt_d = '0;
                    end
                end

                ST_RUN: begin
                    if (capture) begin
                        addr_d   = addr_cnt_q;
                        iter_d   = dec_iter;
                        inside_d = dec_inside;
                        valid_d  = 1'b1;
                        // The last pixel parks the coordinates; only the frame end clears them.
                        if (last_pix) begin
                            state_d = ST_DRAIN;
                        end else begin
                            addr_cnt_d = addr_cnt_q + AW'(1);
                            if (x_q == X_LAST) begin
                                x_d = '0;
                                y_d = y_q + 12'd1;
                            end else begin
                                x_d = x_q + 12'd1;
                            end
                        end
                    end
                end

                ST_DRAIN: begin
                    if (accept) begin
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                        busy_d     = 1'b0;
                        valid_d    = 1'b0;
                        x_d        = '0;
                        y_d        = '0;
                        addr_cnt_d = '0;
                    end
                end

                default: begin
                    state_d    = ST_IDLE;
                    busy_d     = 1'b0;
                    valid_d    = 1'b0;
                    x_d        = '0;
                    y_d        = '0;
                    addr_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            addr_cnt_q <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            iter_q     <= '0;
            inside_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            addr_cnt_q <= addr_cnt_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            iter_q     <= iter_d;
            inside_q   <= inside_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_d;
    assign x_out          = x_q;
    assign y_out          = y_q;
    assign pix.pix_valid  = valid_q;
    assign pix.pix_addr   = addr_q;
    assign pix.pix_iter   = iter_q;
    assign pix.pix_inside = inside_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_fractal_raster_scan.sv
// Bench for fractal_raster_scan on a 4x3 raster: expected records are queued at
// frame start and compared in order as the framebuffer side accepts them.
module tb_fractal_raster_scan;

  localparam int H_RES    = 4;
  localparam int V_RES    = 3;
  localparam int MAX_ITER = 20;
  localparam int ITW      = 5;
  localparam int AW       = 20;
  localparam int NPIX     = H_RES * V_RES;
  localparam int W        = AW + ITW + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [11:0]       x_out;
  logic [11:0]       y_out;
  logic [MAX_ITER:0] iter_in;
  logic [1:0]        dbg_state;

  int                mode;
  logic [MAX_ITER:0] const_iter;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  bit done_seen;

  logic [W-1:0] exp_q[$];

  fractal_raster_scan_if #(.AW(AW), .ITW(ITW)) pix ();

  fractal_raster_scan #(
    .H_RES(H_RES), .V_RES(V_RES), .MAX_ITER(MAX_ITER), .ITW(ITW), .AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .x_out(x_out), .y_out(y_out),
    .iter_in(iter_in), .pix(pix), .dbg_state(dbg_state)
  );

  // clock / global time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // core model: compare vector as a function of the coordinate
  function automatic logic [MAX_ITER:0] model_iter(int md, logic [MAX_ITER:0] cv, int x, int y);
    logic [MAX_ITER:0] v;
    int k;
    v = '0;
    if (md == 0) begin
      v = '1;
    end else if (md == 1) begin
      v = cv;
    end else begin
      k = (x * 7 + y * 5) % (MAX_ITER + 1);
      for (int i = 0; i < k; i++) v[i] = 1'b1;
      v[MAX_ITER] = ((x + y) % 2) == 1;
    end
    return v;
  endfunction

  assign iter_in = model_iter(mode, const_iter, int'(x_out), int'(y_out));

  function automatic int exp_decode(logic [MAX_ITER:0] v);
    int n;
    n = 0;
    while (n < MAX_ITER && v[n]) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && pix.pix_valid && pix.pix_ready) begin
      n_acc++;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("record", 32'({pix.pix_addr, pix.pix_iter, pix.pix_inside}), 32'(e[W-1:1]));
        check("done_on_accept", 32'(done), 32'(e[0]));
      end
    end
    if (done) done_seen = 1'b1;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    logic [MAX_ITER:0] v;
    logic [AW-1:0] a;
    for (int i = 0; i < NPIX; i++) begin
      v = model_iter(mode, const_iter, i % H_RES, i / H_RES);
      a = AW'(i);
      exp_q.push_back({a, ITW'(exp_decode(v)), &v[MAX_ITER-1:0], i == NPIX - 1});
    end
    n_acc = 0;
    done_seen = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_addr(input int a);
    int k;
    k = 0;
    while (k < 60 && !(pix.pix_valid && pix.pix_addr == AW'(a))) begin
      step();
      k++;
    end
    check("wait_addr", 32'(pix.pix_valid && pix.pix_addr == AW'(a)), 32'd1);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done_seen && cycles < 300) begin
      step();
      cycles++;
    end
    check("done_seen", 32'(done_seen), 32'd1);
  endtask

  task automatic check_frame_end(input string tag);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_valid_low"}, 32'(pix.pix_valid), 32'd0);
    check({tag, "_xy_zero"}, 32'({x_out, y_out}), 32'd0);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_accepted"}, 32'(n_acc), 32'(NPIX));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_xy"}, 32'({x_out, y_out}), 32'd0);
    check({tag, "_valid"}, 32'(pix.pix_valid), 32'd0);
    check({tag, "_addr"}, 32'(pix.pix_addr), 32'd0);
    check({tag, "_iter"}, 32'(pix.pix_iter), 32'd0);
    check({tag, "_inside"}, 32'(pix.pix_inside), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic run_const_frame(input string tag, input logic [MAX_ITER:0] cv);
    int cyc;
    mode = 1;
    const_iter = cv;
    push_frame();
    pulse_start();
    wait_done(cyc);
    check({tag, "_cycles"}, 32'(cyc), 32'd13);
    check_frame_end(tag);
  endtask

  // directed sequence
  initial begin
    int cyc;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    pix.pix_ready = 1'b1;
    mode = 0;
    const_iter = '0;
    done_seen = 1'b0;

    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // full-throughput frame, every point inside
    push_frame();
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_state", 32'(dbg_state), 32'd1);
    check("start_valid", 32'(pix.pix_valid), 32'd0);
    wait_done(cyc);
    check("frame_cycles", 32'(cyc), 32'd13);
    check_frame_end("frame_a");
    check("idle_state", 32'(dbg_state), 32'd0);

    // decode boundaries
    run_const_frame("iter_f", 21'h00000F);
    run_const_frame("iter_zero", 21'h000000);
    run_const_frame("iter_top_only", 21'h100000);

    // backpressure at address 5
    mode = 2;
    push_frame();
    pulse_start();
    wait_addr(5);
    pix.pix_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_addr_hold", 32'(pix.pix_addr), 32'd5);
      check("bp_valid_hold", 32'(pix.pix_valid), 32'd1);
      check("bp_xy_frozen", 32'({x_out, y_out}), 32'({12'd2, 12'd1}));
    end
    pix.pix_ready = 1'b1;
    step();
    check("bp_next_addr", 32'(pix.pix_addr), 32'd6);
    check("bp_next_valid", 32'(pix.pix_valid), 32'd1);
    wait_done(cyc);
    check_frame_end("bp");

    // abort at address 7
    push_frame();
    pulse_start();
    wait_addr(7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid", 32'(pix.pix_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_xy", 32'({x_out, y_out}), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_remaining", 32'(exp_q.size()), 32'(NPIX - 8));
    exp_q.delete();
    step();

    // restart after abort, with a stray start mid-frame
    push_frame();
    pulse_start();
    wait_addr(3);
    pulse_start();
    wait_done(cyc);
    check_frame_end("restart");

    // asynchronous reset mid-frame
    push_frame();
    pulse_start();
    wait_addr(4);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();
    check_all_zero("after_reset");

    // random backpressure over a full frame
    push_frame();
    pulse_start();
    cyc = 0;
    while (!done_seen && cyc < 400) begin
      pix.pix_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    pix.pix_ready = 1'b1;
    check("rand_done_seen", 32'(done_seen), 32'd1);
    check_frame_end("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
